// File: rtl/count_mon_pkg.sv
// Shared types and default sizing for the count monitor.
package count_mon_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STABLE = 2;
  localparam int DEF_ERRW   = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYNC = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } state_e;

endpackage

// File: rtl/stab_filter.sv
// Samples the slow count bus and emits a one-cycle acceptance pulse once a
// value has sat unchanged in the sample register for STABLE edges.
module stab_filter #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] count_in,
  output logic             acc_valid,
  output logic [WIDTH-1:0] acc_value
);

  localparam int             HW       = $clog2(STABLE + 1) + 1;
  localparam logic [HW-1:0]  HOLD_MAX = HW'(STABLE);

  logic [WIDTH-1:0] in_q_r;
  logic [HW-1:0]    hold_r;
  logic [HW-1:0]    hold_nx_s;
  logic             changed_s;
  logic             accept_s;
  logic             acc_valid_r;

  // Hold count tracks how many edges the value now entering in_q has been resident.
  always_comb begin
    hold_nx_s = hold_r;
    changed_s = (count_in != in_q_r);
    if (changed_s) begin
      hold_nx_s = HW'(1);
    end else if (hold_r == HOLD_MAX) begin
      hold_nx_s = hold_r;
    end else begin
      hold_nx_s = hold_r + HW'(1);
    end
    // hold_r starts at zero so the very first value after reset is accepted even if it equals in_q.
    accept_s = (hold_nx_s == HOLD_MAX) && (changed_s || (hold_r != HOLD_MAX));
  end

  // Sample register, hold counter and registered acceptance pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      in_q_r      <= '0;
      hold_r      <= '0;
      acc_valid_r <= 1'b0;
    end else begin
      in_q_r      <= count_in;
      hold_r      <= hold_nx_s;
      acc_valid_r <= accept_s;
    end
  end

  assign acc_valid = acc_valid_r;
  assign acc_value = in_q_r;

endmodule

// File: rtl/count_monitor.sv
// Classifies each accepted count change as an up step, down step or illegal
// jump, tracks direction and keeps a saturating error tally.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STABLE = DEF_STABLE,
  parameter int ERRW   = DEF_ERRW
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] count_in,
  output logic             step,
  output logic             dir,
  output logic             dir_valid,
  output logic             dir_change,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [ERRW-1:0]  ERR_MAX = {ERRW{1'b1}};

  logic             acc_valid_s;
  logic [WIDTH-1:0] acc_value_s;
  logic             up_s;
  logic             down_s;
  logic             same_s;

  state_e           state_r, state_nx_s;
  logic             step_r, step_nx_s;
  logic             err_r, err_nx_s;
  logic             dir_change_r, dir_change_nx_s;
  logic             dir_r, dir_nx_s;
  logic             dir_valid_r, dir_valid_nx_s;
  logic [WIDTH-1:0] value_r, value_nx_s;
  logic [ERRW-1:0]  err_cnt_r, err_cnt_nx_s;

  stab_filter #(
    .WIDTH  (WIDTH),
    .STABLE (STABLE)
  ) u_filter (
    .clk       (clk),
    .nrst      (nrst),
    .count_in  (count_in),
    .acc_valid (acc_valid_s),
    .acc_value (acc_value_s)
  );

  // The last accepted value is the reference; arithmetic wraps at WIDTH bits.
  assign up_s   = (acc_value_s == value_r + ONE);
  assign down_s = (acc_value_s == value_r - ONE);
  assign same_s = (acc_value_s == value_r);

  // Next-state and next-output decode for each acceptance.
  always_comb begin
    state_nx_s      = state_r;
    step_nx_s       = 1'b0;
    err_nx_s        = 1'b0;
    dir_change_nx_s = 1'b0;
    dir_nx_s        = dir_r;
    dir_valid_nx_s  = dir_valid_r;
    value_nx_s      = value_r;
    if (!acc_valid_s) begin
      state_nx_s = state_r;
    end else if (state_r == ST_INIT) begin
      value_nx_s = acc_value_s;
      state_nx_s = ST_SYNC;
    end else if (same_s) begin
      state_nx_s = state_r;
    end else begin
      value_nx_s = acc_value_s;
      if (up_s) begin
        step_nx_s       = 1'b1;
        dir_nx_s        = 1'b1;
        dir_valid_nx_s  = 1'b1;
        dir_change_nx_s = (state_r == ST_DOWN);
        state_nx_s      = ST_UP;
      end else if (down_s) begin
        step_nx_s       = 1'b1;
        dir_nx_s        = 1'b0;
        dir_valid_nx_s  = 1'b1;
        dir_change_nx_s = (state_r == ST_UP);
        state_nx_s      = ST_DOWN;
      end else begin
        // Illegal jump: drop direction confidence but keep dir for display.
        err_nx_s       = 1'b1;
        dir_valid_nx_s = 1'b0;
        state_nx_s     = ST_SYNC;
      end
    end

    if (err_nx_s && (err_cnt_r != ERR_MAX)) begin
      err_cnt_nx_s = err_cnt_r + ERRW'(1);
    end else begin
      err_cnt_nx_s = err_cnt_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= ST_INIT;
      step_r       <= 1'b0;
      err_r        <= 1'b0;
      dir_change_r <= 1'b0;
      dir_r        <= 1'b0;
      dir_valid_r  <= 1'b0;
      value_r      <= '0;
      err_cnt_r    <= '0;
    end else begin
      state_r      <= state_nx_s;
      step_r       <= step_nx_s;
      err_r        <= err_nx_s;
      dir_change_r <= dir_change_nx_s;
      dir_r        <= dir_nx_s;
      dir_valid_r  <= dir_valid_nx_s;
      value_r      <= value_nx_s;
      err_cnt_r    <= err_cnt_nx_s;
    end
  end

  assign step       = step_r;
  assign err        = err_r;
  assign dir_change = dir_change_r;
  assign dir        = dir_r;
  assign dir_valid  = dir_valid_r;
  assign value      = value_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor with an event scoreboard fed by a
// behavioural model of the step/error classification.
module tb_count_monitor;

  localparam int WIDTH  = 4;
  localparam int STABLE = 2;
  localparam int ERRW   = 8;

  logic             clk = 1'b0;
  logic             nrst;
  logic [WIDTH-1:0] count_in;
  logic             step, dir, dir_valid, dir_change, err;
  logic [ERRW-1:0]  err_cnt;
  logic [WIDTH-1:0] value;

  typedef struct packed {
    logic             step;
    logic             err;
    logic             dc;
    logic             dir;
    logic             dv;
    logic [WIDTH-1:0] value;
    logic [ERRW-1:0]  errcnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  int              m_state;
  logic [WIDTH-1:0] m_ref;
  logic            m_dir, m_dv;
  logic [ERRW-1:0] m_errcnt;

  count_monitor #(.WIDTH(WIDTH), .STABLE(STABLE), .ERRW(ERRW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .count_in   (count_in),
    .step       (step),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .dir_change (dir_change),
    .err        (err),
    .err_cnt    (err_cnt),
    .value      (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_ref    = '0;
    m_dir    = 1'b0;
    m_dv     = 1'b0;
    m_errcnt = '0;
    exp_q.delete();
  endtask

  // States: 0 init, 1 sync, 2 up, 3 down.
  task automatic model_accept(input logic [WIDTH-1:0] v);
    ev_t e;
    logic [WIDTH-1:0] up_v, dn_v;
    up_v = m_ref + WIDTH'(1);
    dn_v = m_ref - WIDTH'(1);
    if (m_state == 0) begin
      m_ref   = v;
      m_state = 1;
    end else if (v != m_ref) begin
      e = '0;
      if (v == up_v) begin
        e.step = 1'b1; e.dc = (m_state == 3); m_dir = 1'b1; m_dv = 1'b1; m_state = 2;
      end else if (v == dn_v) begin
        e.step = 1'b1; e.dc = (m_state == 2); m_dir = 1'b0; m_dv = 1'b1; m_state = 3;
      end else begin
        e.err = 1'b1; m_dv = 1'b0; m_state = 1;
        if (m_errcnt != {ERRW{1'b1}}) m_errcnt = m_errcnt + ERRW'(1);
      end
      m_ref    = v;
      e.dir    = m_dir;
      e.dv     = m_dv;
      e.value  = v;
      e.errcnt = m_errcnt;
      exp_q.push_back(e);
    end
  endtask

  // Drive v from a falling edge for n rising edges.
  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    count_in = v;
    if (n >= STABLE) model_accept(v);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (STABLE + 3) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every step/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t got, e;
    if (nrst && (step || err)) begin
      got = {step, err, dir_change, dir, dir_valid, value, err_cnt};
      check("pulse_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    nrst     = 1'b1;
    count_in = WIDTH'(5);
    model_reset();
    #1 nrst = 1'b0;
    #1 check("reset_outputs", 64'({step, err, dir_change, dir, dir_valid, value, err_cnt}), 64'd0);

    // Held 5 after reset: sync only.
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    model_accept(WIDTH'(5));
    @(negedge clk); @(negedge clk);
    check("value_before_accept", 64'(value), 64'd0);
    @(negedge clk);
    check("value_synced", 64'(value), 64'd5);
    check("dir_valid_synced", 64'(dir_valid), 64'd0);
    repeat (6) @(negedge clk);

    // 5 -> 6 with exact latency, then 7.
    count_in = WIDTH'(6);
    model_accept(WIDTH'(6));
    repeat (STABLE) @(negedge clk);
    check("latency_early", 64'(step), 64'd0);
    @(negedge clk);
    check("latency_step", 64'(step), 64'd1);
    repeat (7) @(negedge clk);
    hold(WIDTH'(7), 10);
    drain("drain_up");
    check("dir_up", 64'(dir), 64'd1);
    check("dir_valid_up", 64'(dir_valid), 64'd1);
    check("err_cnt_zero", 64'(err_cnt), 64'd0);

    // Walk up through the wrap, then reverse.
    for (int v = 8; v <= 15; v++) hold(WIDTH'(v), 4);
    hold(WIDTH'(0), 4);
    hold(WIDTH'(1), 4);
    drain("drain_wrap_up");
    check("err_cnt_wrap", 64'(err_cnt), 64'd0);
    hold(WIDTH'(0), 4);
    hold(WIDTH'(15), 4);
    drain("drain_wrap_down");
    check("dir_down", 64'(dir), 64'd0);
    check("value_15", 64'(value), 64'd15);

    // Walk down to 3, jump to 9, recover with 10.
    for (int v = 14; v >= 3; v--) hold(WIDTH'(v), 4);
    hold(WIDTH'(9), 4);
    drain("drain_jump");
    check("err_cnt_one", 64'(err_cnt), 64'd1);
    check("dir_valid_after_err", 64'(dir_valid), 64'd0);
    check("dir_held_after_err", 64'(dir), 64'd0);
    hold(WIDTH'(10), 4);
    drain("drain_recover");
    check("dir_recover", 64'(dir), 64'd1);
    check("dir_valid_recover", 64'(dir_valid), 64'd1);

    // Glitch shorter than STABLE is invisible; a stable one errs twice.
    hold(WIDTH'(4), 4);
    hold(WIDTH'(7), 1);
    hold(WIDTH'(4), 6);
    drain("drain_glitch");
    check("err_cnt_glitch", 64'(err_cnt), 64'd2);
    hold(WIDTH'(7), 2);
    hold(WIDTH'(4), 4);
    drain("drain_stable_glitch");
    check("err_cnt_stable_glitch", 64'(err_cnt), 64'd4);

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) hold((i % 2 == 0) ? WIDTH'(0) : WIDTH'(8), STABLE);
    drain("drain_saturate");
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);

    // Asynchronous reset in the middle of activity.
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? WIDTH'(3) : WIDTH'(11), STABLE);
    count_in = WIDTH'(2);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1 check("async_reset_outputs", 64'({step, err, dir_change, dir, dir_valid, value, err_cnt}), 64'd0);
    model_reset();
    count_in = WIDTH'(5);
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    model_accept(WIDTH'(5));
    repeat (4) @(negedge clk);
    check("value_after_reset", 64'(value), 64'd5);
    check("dir_valid_after_reset", 64'(dir_valid), 64'd0);
    check("err_cnt_after_reset", 64'(err_cnt), 64'd0);
    hold(WIDTH'(6), 4);
    drain("drain_after_reset");
    check("dir_after_reset", 64'(dir), 64'd1);
    check("dir_valid_after_step", 64'(dir_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
